// File: rtl/conv2d_mac_multichan_pkg.sv
// Shared sizing helpers, pipeline stage tag and output saturation
// for the multichannel KxK convolution MAC.
package conv_mac_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } stage_tag_t;

    function automatic int tap_count(input int filt_dim);
        return filt_dim * filt_dim;
    endfunction

    function automatic int acc_width(input int bit_width, input int filt_dim, input int nchan);
        return bit_width + $clog2(filt_dim * filt_dim * nchan);
    endfunction

    // Clamp a wide signed value into a bw-bit two's-complement range.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int bw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv2d_mac_multichan_if.sv
// Window-in / pixel-out valid-ready stream bundle for conv2d_mac_multichan.
interface conv2d_mac_multichan_if #(
    parameter int FILT_DIM  = 3,
    parameter int BIT_WIDTH = 16
);
    logic                                             in_valid;
    logic                                             in_ready;
    logic [FILT_DIM-1:0][FILT_DIM-1:0][BIT_WIDTH-1:0] window;
    logic                                             out_valid;
    logic                                             out_ready;
    logic signed [BIT_WIDTH-1:0]                      out_data;

    modport master (output in_valid, window, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, window, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/conv_adder_tree.sv
// Registered signed reduction of N inputs; output grows by clog2(N) bits so it never wraps.
module conv_adder_tree #(
    parameter int N    = 9,
    parameter int W_IN = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              en,
    input  logic [N-1:0][W_IN-1:0]            din,
    output logic signed [W_IN+$clog2(N)-1:0]  sum
);
    localparam int W_OUT = W_IN + $clog2(N);

    logic signed [W_OUT-1:0] sum_d;

    // NOTE: blocking '=' here because sum_d is a running combinational value, not state.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_d = sum_d + W_OUT'($signed(din[i]));
        end
    end

    // NOTE: registers use '<=' so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)   sum <= '0;
        else if (en) sum <= sum_d;
    end
endmodule

// File: rtl/conv2d_mac_multichan.sv
// KxK multichannel convolution MAC: input reg, truncated products, adder tree,
// channel accumulator, bias + saturate + optional ReLU, valid/ready output.
module conv2d_mac_multichan
    import conv_mac_pkg::*;
#(
    parameter int FILT_DIM  = 3,
    parameter int BIT_WIDTH = 16,
    parameter int NFRAC     = 10,
    parameter int NCHAN     = 4,
    parameter int RELU      = 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    conv2d_mac_multichan_if.slave                       bus,
    input  logic                                        wt_we,
    input  logic [$clog2(NCHAN*FILT_DIM*FILT_DIM)-1:0]  wt_addr,
    input  logic signed [BIT_WIDTH-1:0]                 wt_data,
    input  logic                                        bias_we,
    input  logic signed [BIT_WIDTH-1:0]                 bias_data,
    output logic                                        busy,
    output logic                                        wt_err
);
    localparam int TAPS   = tap_count(FILT_DIM);
    localparam int TREE_W = BIT_WIDTH + $clog2(TAPS);
    localparam int ACC_W  = acc_width(BIT_WIDTH, FILT_DIM, NCHAN);
    localparam int ADDR_W = $clog2(NCHAN * TAPS);
    localparam int CH_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic signed [BIT_WIDTH-1:0]                      weights [NCHAN*TAPS];
    logic signed [BIT_WIDTH-1:0]                      bias_q;
    logic [CH_W-1:0]                                  ch_q, s0_ch_q;
    logic                                             ready_q, stall, accept;
    stage_tag_t                                       s0_tag, s1_tag, s2_tag, s3_tag;
    logic [FILT_DIM-1:0][FILT_DIM-1:0][BIT_WIDTH-1:0] win_q;
    logic [TAPS-1:0][BIT_WIDTH-1:0]                   prod_d, prod_q;
    logic signed [TREE_W-1:0]                         tree_sum;
    logic signed [ACC_W-1:0]                          acc_q, tree_ext;
    logic signed [63:0]                               r_wide, r_sat;
    logic signed [BIT_WIDTH-1:0]                      result_d, out_data_q;
    logic                                             out_valid_q;

    assign stall         = out_valid_q && !bus.out_ready;
    assign bus.in_ready  = ready_q && !stall;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = s0_tag.valid || s1_tag.valid || s2_tag.valid || s3_tag.valid || out_valid_q;
    assign tree_ext      = ACC_W'(tree_sum);

    // Product bits [NFRAC+BW-1:NFRAC] of the full product: floor toward -inf.
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        logic signed [2*BIT_WIDTH-1:0] full;
        logic [ADDR_W-1:0]             idx;
        assign idx       = ADDR_W'(int'(s0_ch_q) * TAPS + t);
        assign full      = $signed(win_q[t / FILT_DIM][t % FILT_DIM]) * weights[idx];
        assign prod_d[t] = full[NFRAC+BIT_WIDTH-1:NFRAC];
    end

    conv_adder_tree #(.N(TAPS), .W_IN(BIT_WIDTH)) u_tree (
        .clock (clock),
        .reset (reset),
        .en    (!stall),
        .din   (prod_q),
        .sum   (tree_sum)
    );

    always_comb begin
        r_wide   = 64'(acc_q) + 64'(bias_q);
        r_sat    = saturate(r_wide, BIT_WIDTH);
        result_d = r_sat[BIT_WIDTH-1:0];
        if (RELU != 0 && result_d[BIT_WIDTH-1]) result_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            ch_q    <= '0;
        end else begin
            ready_q <= 1'b1;
            if (accept) ch_q <= (ch_q == CH_W'(NCHAN - 1)) ? '0 : ch_q + 1'b1;
        end
    end

    // Every stage advances together; a stalled output freezes the whole pipe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_tag      <= '0;
            s1_tag      <= '0;
            s2_tag      <= '0;
            s3_tag      <= '0;
            s0_ch_q     <= '0;
            win_q       <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (!stall) begin
            s0_tag  <= '{valid: accept, first: (ch_q == '0), last: (ch_q == CH_W'(NCHAN - 1))};
            s0_ch_q <= ch_q;
            win_q   <= bus.window;
            s1_tag  <= s0_tag;
            prod_q  <= prod_d;
            s2_tag  <= s1_tag;
            s3_tag  <= s2_tag;
            if (s2_tag.valid) acc_q <= s2_tag.first ? tree_ext : acc_q + tree_ext;
            if (s3_tag.valid && s3_tag.last) begin
                out_data_q  <= result_d;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // NOTE: the weight and bias storage is reset too: cleared weights are part of the defined reset state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCHAN * TAPS; i++) weights[i] <= '0;
            bias_q <= '0;
            wt_err <= 1'b0;
        end else begin
            wt_err <= (wt_we || bias_we) && busy;
            if (wt_we && !busy)   weights[wt_addr] <= wt_data;
            if (bias_we && !busy) bias_q <= bias_data;
        end
    end
endmodule

// File: tb/tb_conv2d_mac_multichan.sv
// Self-checking bench: table vectors, hand-written corner sequences and a
// randomized run against a plain-arithmetic pixel model. Two DUTs: RELU=1 and RELU=0.
module tb_conv2d_mac_multichan;
    localparam int K     = 3;
    localparam int BW    = 16;
    localparam int NFRAC = 10;
    localparam int NCHAN = 4;
    localparam int NW    = NCHAN * K * K;

    typedef logic [K-1:0][K-1:0][BW-1:0] win_t;
    typedef struct {
        string name;
        int    win;
        int    wt;
        int    bias;
        int    exp_relu;
        int    exp_norelu;
    } vec_t;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               wt_we = 1'b0;
    logic               bias_we = 1'b0;
    logic [5:0]         wt_addr = '0;
    logic signed [15:0] wt_data = '0;
    logic signed [15:0] bias_data = '0;
    logic               busy, wt_err, busy_nr, wt_err_nr;

    int      checks = 0;
    int      failures = 0;
    shortint wt_m [NW];
    shortint bias_m = 0;
    logic signed [BW-1:0] got_q[$], got_nr_q[$];
    int      exp_q[$], exp_nr_q[$];
    win_t    beats_q[$];
    vec_t    vecs [6];
    bit      done;

    always #5 clock = ~clock;

    conv2d_mac_multichan_if #(.FILT_DIM(K), .BIT_WIDTH(BW)) bus ();
    conv2d_mac_multichan_if #(.FILT_DIM(K), .BIT_WIDTH(BW)) bus_nr ();

    conv2d_mac_multichan #(.FILT_DIM(K), .BIT_WIDTH(BW), .NFRAC(NFRAC), .NCHAN(NCHAN), .RELU(1)) dut (
        .clock(clock), .reset(reset), .bus(bus), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_we(bias_we), .bias_data(bias_data), .busy(busy), .wt_err(wt_err));

    conv2d_mac_multichan #(.FILT_DIM(K), .BIT_WIDTH(BW), .NFRAC(NFRAC), .NCHAN(NCHAN), .RELU(0)) dut_nr (
        .clock(clock), .reset(reset), .bus(bus_nr), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_we(bias_we), .bias_data(bias_data), .busy(busy_nr), .wt_err(wt_err_nr));

    always @(posedge clock) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready)       got_q.push_back(bus.out_data);
            if (bus_nr.out_valid && bus_nr.out_ready) got_nr_q.push_back(bus_nr.out_data);
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic win_t fill(input int v, input int v00);
        win_t w;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[r][c] = 16'(v);
        w[0][0] = 16'(v00);
        return w;
    endfunction

    // Reference: sum over channels and taps of floor(x*w / 2^NFRAC) wrapped to BW bits,
    // plus bias, clamped to BW-bit range, then optional ReLU.
    function automatic int model_pixel(input win_t w[NCHAN], input bit relu);
        longint s = 0;
        longint p;
        for (int c = 0; c < NCHAN; c++)
            for (int r = 0; r < K; r++)
                for (int col = 0; col < K; col++) begin
                    p = longint'($signed(w[c][r][col])) * longint'(wt_m[c*K*K + r*K + col]);
                    s += longint'(shortint'(p >>> NFRAC));
                end
        s += longint'(bias_m);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return int'(s);
    endfunction

    task automatic drive_in(input logic v, input win_t w);
        bus.in_valid = v;    bus.window = w;
        bus_nr.in_valid = v; bus_nr.window = w;
    endtask

    task automatic set_ready(input logic r);
        bus.out_ready = r;
        bus_nr.out_ready = r;
    endtask

    // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
    task automatic send_beat(input win_t w);
        int n = 0;
        drive_in(1'b1, w);
        #2;
        while (!bus.in_ready && n < 200) begin
            @(posedge clock); #3;
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", n);
        end
        @(posedge clock); #1;
        drive_in(1'b0, w);
    endtask

    task automatic write_wt(input int addr, input int data);
        wt_we = 1'b1; wt_addr = 6'(addr); wt_data = 16'(data);
        @(posedge clock); #1;
        wt_we = 1'b0;
        wt_m[addr] = shortint'(data);
    endtask

    task automatic write_bias(input int data);
        bias_we = 1'b1; bias_data = 16'(data);
        @(posedge clock); #1;
        bias_we = 1'b0;
        bias_m = shortint'(data);
    endtask

    task automatic load_all(input int v);
        for (int i = 0; i < NW; i++) write_wt(i, v);
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (got_q.size() < n && k < 300) begin
            @(posedge clock); #1;
            k++;
        end
        if (got_q.size() < n) begin
            failures++;
            $display("FAIL result_timeout: got %0d results, expected %0d", got_q.size(), n);
        end
    endtask

    task automatic take(input string name, input int exp_r, input int exp_nr);
        wait_results(1);
        if (got_q.size() > 0)    check({name, "_relu"}, got_q.pop_front(), exp_r);
        if (got_nr_q.size() > 0) check({name, "_norelu"}, got_nr_q.pop_front(), exp_nr);
    endtask

    task automatic send_pixel_uniform(input int v, input int v00);
        for (int c = 0; c < NCHAN; c++) send_beat(fill(v, v00));
    endtask

    // Builds npix random pixels into beats_q with their expected results.
    task automatic gen_pixels(input int npix, input int range);
        win_t one [NCHAN];
        for (int p = 0; p < npix; p++) begin
            for (int c = 0; c < NCHAN; c++) begin
                for (int r = 0; r < K; r++)
                    for (int col = 0; col < K; col++)
                        one[c][r][col] = 16'($urandom_range(0, 2 * range) - range);
                beats_q.push_back(one[c]);
            end
            exp_q.push_back(model_pixel(one, 1'b1));
            exp_nr_q.push_back(model_pixel(one, 1'b0));
        end
    endtask

    task automatic compare_queued(input string name);
        while (exp_q.size() > 0) begin
            if (got_q.size() > 0)    check({name, "_relu"}, got_q.pop_front(), exp_q[0]);
            else begin failures++; $display("FAIL %s_missing: no result, expected %0d", name, exp_q[0]); end
            if (got_nr_q.size() > 0) check({name, "_norelu"}, got_nr_q.pop_front(), exp_nr_q[0]);
            void'(exp_q.pop_front());
            void'(exp_nr_q.pop_front());
        end
    endtask

    initial begin
        int lat;
        int n;
        logic signed [BW-1:0] hold;

        vecs[0] = '{"ones",      1,     1024,  0,  36,     36};
        vecs[1] = '{"sat_pos",   16000, 1024,  0,  32767,  32767};
        vecs[2] = '{"sat_neg",   16000, -1024, 0,  0,      -32768};
        vecs[3] = '{"neg_small", -1,    1024,  0,  0,      -36};
        vecs[4] = '{"half_wt",   2,     512,   -5, 31,     31};
        vecs[5] = '{"floor",     -1,    512,   7,  0,      -29};

        for (int i = 0; i < NW; i++) wt_m[i] = 0;
        drive_in(1'b0, '0);
        set_ready(1'b1);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_wt_err", wt_err, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("in_ready_after_reset", bus.in_ready, 1);

        // Table-driven uniform vectors
        for (int i = 0; i < 6; i++) begin
            load_all(vecs[i].wt);
            write_bias(vecs[i].bias);
            send_pixel_uniform(vecs[i].win, vecs[i].win);
            take(vecs[i].name, vecs[i].exp_relu, vecs[i].exp_norelu);
        end

        // Latency: out_valid 4 cycles after the last-channel accept
        load_all(1024);
        write_bias(0);
        send_pixel_uniform(1, 1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check("latency", lat, 4);
        check("latency_data", bus.out_data, 36);
        take("latency_px", 36, 36);

        // Tap 0 only, weight 0.5: floor behaviour and bias
        load_all(0);
        for (int c = 0; c < NCHAN; c++) write_wt(c * K * K, 512);
        write_bias(100);
        send_pixel_uniform(5, 3);
        take("tap0_pos_bias", 104, 104);
        send_pixel_uniform(5, -3);
        take("tap0_neg_bias", 92, 92);
        write_bias(0);
        send_pixel_uniform(5, -3);
        take("tap0_neg", 0, -8);

        // Randomized back-to-back pixels with random backpressure
        for (int i = 0; i < NW; i++) write_wt(i, int'($urandom_range(0, 4096)) - 2048);
        write_bias(int'($urandom_range(0, 8192)) - 4096);
        gen_pixels(5, 1024);
        gen_pixels(1, 32767);
        done = 1'b0;
        fork
            begin
                while (beats_q.size() > 0) send_beat(beats_q.pop_front());
                done = 1'b1;
            end
            begin
                while (!done) begin
                    set_ready(1'($urandom_range(0, 1)));
                    @(posedge clock); #1;
                end
                set_ready(1'b1);
            end
        join
        wait_results(6);
        compare_queued("rand_px");

        // Stall: two back-to-back pixels, out_ready held low for 3 cycles
        gen_pixels(2, 1024);
        set_ready(1'b0);
        fork
            begin
                while (beats_q.size() > 0) send_beat(beats_q.pop_front());
            end
            begin
                n = 0;
                while (!bus.out_valid && n < 100) begin
                    @(posedge clock); #1;
                    n++;
                end
                if (n >= 100) begin
                    failures++;
                    $display("FAIL stall_timeout: out_valid never rose");
                end
                hold = bus.out_data;
                for (int s = 0; s < 3; s++) begin
                    check("stall_in_ready", bus.in_ready, 0);
                    check("stall_out_valid", bus.out_valid, 1);
                    if (s > 0) check("stall_data_held", bus.out_data, hold);
                    @(posedge clock); #1;
                end
                set_ready(1'b1);
            end
        join
        wait_results(2);
        compare_queued("stall_px");
        repeat (10) @(posedge clock);
        #1;
        check("stall_no_duplicate", got_q.size(), 0);

        // Reset mid-pixel discards the partial sum
        send_beat(fill(7, 7));
        send_beat(fill(7, 7));
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        reset = 1'b0;
        for (int i = 0; i < NW; i++) wt_m[i] = 0;
        bias_m = 0;
        got_q.delete();
        got_nr_q.delete();
        @(posedge clock); #1;
        load_all(1024);
        send_pixel_uniform(1, 1);
        take("after_reset", 36, 36);

        // Writes while busy are dropped and flagged; the same write when idle lands
        send_pixel_uniform(1, 1);
        check("busy_during", busy, 1);
        wt_we = 1'b1; wt_addr = 6'd0; wt_data = 16'sd0;
        bias_we = 1'b1; bias_data = 16'sd500;
        @(posedge clock); #1;
        wt_we = 1'b0; bias_we = 1'b0;
        check("wt_err_pulse", wt_err, 1);
        @(posedge clock); #1;
        check("wt_err_clear", wt_err, 0);
        take("busy_write_dropped", 36, 36);
        check("busy_idle", busy, 0);
        write_wt(0, 0);
        check("idle_write_no_err", wt_err, 0);
        send_pixel_uniform(1, 1);
        take("idle_write_applied", 35, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv2d_mac_multichan.md
# conv2d_mac_multichan

Parametrised K×K convolution MAC for the 2D CNN datapath. Each accepted beat is one K×K input window for one input channel. Products are formed against run-time-loaded per-channel weights and reduced by a registered adder tree. The block accumulates across NCHAN input channels, adds a bias, saturates, applies an optional ReLU, and emits one output pixel behind a valid/ready handshake. It replaces the fixed 3×3, single-channel, compile-time-weight summer.

## Interface
- FILT_DIM, 3, window side K
- BIT_WIDTH, 16, signed fixed-point data, weight and bias width
- NFRAC, 10, fractional bits (1.0 = 2^NFRAC)
- NCHAN, 4, input channels accumulated per output pixel (≥1)
- RELU, 1, 1 = clamp negative outputs to 0
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  window beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- window  in  signed [BIT_WIDTH-1:0] [K][K]  input window
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  signed [BIT_WIDTH-1:0]  result pixel
- wt_we  in  1  weight write strobe
- wt_addr  in  $clog2(NCHAN*K*K)  address = ch*K*K + row*K + col
- wt_data  in  signed [BIT_WIDTH-1:0]  weight value
- bias_we  in  1  bias write strobe
- bias_data  in  signed [BIT_WIDTH-1:0]  bias value
- busy  out  1  any beat in flight or out_valid high
- wt_err  out  1  one-cycle pulse when a write is rejected

## Operation
- Weight RAM (NCHAN*K*K regs) and bias reg reset to 0. Writes land on the clock edge and are accepted only when busy=0.
- A wt_we or bias_we with busy=1 is dropped: storage is unchanged and wt_err pulses next cycle. Simultaneous wt_we and bias_we are both applied.
- Channel counter ch (0..NCHAN-1) increments per accepted beat and wraps to 0 after NCHAN-1. Beat uses weights of channel ch and carries tags first=(ch==0) and last=(ch==NCHAN-1).
- S1: full 2*BIT_WIDTH products per tap; take bits [NFRAC+BIT_WIDTH-1:NFRAC] (arithmetic truncation, rounds toward −∞). Register.
- S2: adder tree over K*K truncated products, width BIT_WIDTH+$clog2(K*K), no wrap. Register.
- S3: accumulator ACC_W = BIT_WIDTH+$clog2(K*K*NCHAN). first → acc=tree; else acc+=tree.
- S4: on last, r = acc + sign-extended bias. Saturate r to [−2^(BW−1), 2^(BW−1)−1], then apply ReLU if RELU=1. Load out_data and set out_valid.
- Stall: stall = out_valid && !out_ready. While stalled, all stages hold and in_ready=0; otherwise in_ready=1.
- out_valid clears on handshake unless a new result loads the same cycle.

## Timing
- Reset values: in_ready=0 during reset then 1; out_valid=0, out_data=0, busy=0, wt_err=0, ch=0, acc=0.
- Latency: out_valid rises 4 cycles after the accepting edge of the last-channel beat (no stall). Each stall cycle adds one.
- Throughput: one beat per cycle, i.e. one pixel per NCHAN cycles.
- busy goes to 0 the cycle after the final output handshake with nothing in flight.
- Reset mid-pixel discards partial accumulation. The next accepted beat is channel 0.

## Structure
- Package conv_mac_pkg: tap-count and ACC_W constants, a saturate function and a stage-tag struct {valid, first, last}.
- One sub-module: conv_adder_tree (parametrised N inputs, registered output, sign-extending growth).

## Test plan
- All weights 1024, bias 0, four beats of all-1 windows → out_data=36 exactly 4 cycles after the 4th accept.
- Weight 512 on tap 0 only, NCHAN beats with window[0][0]=3 → per-channel 1; with −3 → −2 (floor). Bias 100 → 104 and 92.
- Windows 16000, weights 1024 → 32767. Weights −1024 → 0 with RELU=1, −32768 with RELU=0.
- Back-to-back pixels, out_ready low for 3 cycles → out_data held, in_ready=0, and no beat lost or duplicated.
- Assert reset after 2 channel beats, then send 4 beats of value 1 → 36, not polluted.
- wt_we during busy → wt_err pulses one cycle and the readback result is unchanged. The same write when idle takes effect.
